axi_sram_responder: RTL and testbench

AXI_SRAM_RESPONDER -- requirements
Module: axi_sram_responder

---
 rtl/axi_sram_responder_pkg.sv | 19 +
 rtl/axi_sram_responder_sram_1rw.sv | 35 +++
 rtl/axi_sram_responder.sv | 181 ++++++++++++++++++
 tb/tb_axi_sram_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_responder_pkg.sv
// Shared definitions for the AXI SRAM responder: bus widths, AXI response codes and FSM state encoding.
package axi_sram_responder_pkg;

    localparam int BUS_WIDTH  = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

endpackage

// File: rtl/axi_sram_responder_sram_1rw.sv
// Single-port word array with byte write enables and a one-cycle synchronous read.
// The read register holds its value whenever the port is not enabled for a read.
module sram_1rw #(
    parameter int AW = 12,
    parameter int DW = 32,
    parameter int BW = DW / 8
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [BW-1:0] i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we == '0) begin
                r_rdata <= r_mem[i_addr];
            end else begin
                for (int b = 0; b < BW; b++) begin
                    if (i_we[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 INCR-burst responder in front of a single-port SRAM; one outstanding transaction,
// reads take priority over writes, out-of-range beats answer SLVERR.
module axi_sram_responder
    import axi_sram_responder_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int BUS_W  = BUS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [BUS_W-1:0]      araddr,
    input  logic [7:0]            arlen,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [BUS_W-1:0]      awaddr,
    input  logic [7:0]            awlen,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp
);

    localparam int WA = BUS_W - 2;

    state_t          r_state;
    logic [WA-1:0]   r_start;
    logic [7:0]      r_len;
    logic [7:0]      r_beat;
    logic            r_idle_rdy;
    logic            r_rvalid;
    logic            r_rlast;
    logic            r_rerr;
    logic            r_wready;
    logic            r_bvalid;
    logic            r_berr;

    logic                  w_ar_fire;
    logic                  w_aw_fire;
    logic                  w_r_fire;
    logic                  w_w_fire;
    logic [7:0]            w_beat_idx;
    logic [WA:0]           w_word;
    logic                  w_oor;
    logic                  w_rd_en;
    logic                  w_wr_en;
    logic                  w_final_beat;
    logic [DATA_WIDTH-1:0] w_mem_q;
    logic                  w_unused;

    assign w_ar_fire = r_idle_rdy & arvalid;
    assign w_aw_fire = r_idle_rdy & awvalid & ~arvalid;
    assign w_r_fire  = r_rvalid & rready;
    assign w_w_fire  = r_wready & wvalid;

    // While a read beat is being consumed the following beat is looked up, so beats stream one per cycle.
    assign w_beat_idx = (r_state == RD_DATA) ? r_beat + 8'd1 : r_beat;

    // The extra top bit catches wrap past the end of the word address space.
    assign w_word       = {1'b0, r_start} + {{(WA-7){1'b0}}, w_beat_idx};
    assign w_oor        = (w_word >> MEM_AW) != '0;
    assign w_final_beat = (r_beat == r_len);

    assign w_rd_en = (r_state == RD_ISSUE) | ((r_state == RD_DATA) & w_r_fire & ~r_rlast);
    assign w_wr_en = (r_state == WR_DATA) & w_w_fire & ~w_oor;

    assign w_unused = ^{araddr[1:0], awaddr[1:0]};

    sram_1rw #(
        .AW (MEM_AW),
        .DW (DATA_WIDTH)
    ) u_sram (
        .i_clk   (clk),
        .i_en    (w_rd_en | w_wr_en),
        .i_we    (w_wr_en ? wstrb : '0),
        .i_addr  (w_word[MEM_AW-1:0]),
        .i_wdata (wdata),
        .o_rdata (w_mem_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_start    <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_idle_rdy <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rerr     <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_berr     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_idle_rdy <= 1'b1;
                    r_beat     <= '0;
                    if (w_ar_fire) begin
                        r_state    <= RD_ISSUE;
                        r_start    <= araddr[BUS_W-1:2];
                        r_len      <= arlen;
                        r_idle_rdy <= 1'b0;
                    end else if (w_aw_fire) begin
                        r_state    <= WR_DATA;
                        r_start    <= awaddr[BUS_W-1:2];
                        r_len      <= awlen;
                        r_idle_rdy <= 1'b0;
                        r_wready   <= 1'b1;
                        r_berr     <= 1'b0;
                    end
                end
                RD_ISSUE: begin
                    r_state  <= RD_DATA;
                    r_rvalid <= 1'b1;
                    r_rerr   <= w_oor;
                    r_rlast  <= w_final_beat;
                end
                RD_DATA: begin
                    if (w_r_fire) begin
                        if (r_rlast) begin
                            r_state    <= IDLE;
                            r_rvalid   <= 1'b0;
                            r_rlast    <= 1'b0;
                            r_rerr     <= 1'b0;
                            r_idle_rdy <= 1'b1;
                        end else begin
                            r_beat  <= w_beat_idx;
                            r_rerr  <= w_oor;
                            r_rlast <= (w_beat_idx == r_len);
                        end
                    end
                end
                WR_DATA: begin
                    // A misplaced wlast only poisons the response; the burst length still comes from awlen.
                    if (w_w_fire) begin
                        r_berr <= r_berr | w_oor | (wlast != w_final_beat);
                        if (w_final_beat) begin
                            r_state  <= WR_RESP;
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        r_state    <= IDLE;
                        r_bvalid   <= 1'b0;
                        r_idle_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign arready = r_idle_rdy;
    assign awready = r_idle_rdy & ~arvalid;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rdata   = (r_rvalid & ~r_rerr) ? w_mem_q : '0;
    assign rresp   = (r_rvalid & r_rerr) ? RESP_SLVERR : RESP_OKAY;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = (r_bvalid & r_berr) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: bursts, read stalls, read/write arbitration,
// byte strobes, out-of-range beats, wlast mismatch and reset mid-burst.
module tb_axi_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    int total = 0;
    int bad   = 0;

    logic [31:0] expData [0:15];
    logic [1:0]  expResp [0:15];
    logic [31:0] wrData  [0:15];
    logic [1:0]  respSeen;

    always #5 clk = ~clk;

    axi_sram_responder #(
        .MEM_AW (12),
        .BUS_W  (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arlen   (arlen),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        arvalid = 1'b0;
        araddr  = '0;
        arlen   = '0;
        rready  = 1'b0;
        awvalid = 1'b0;
        awaddr  = '0;
        awlen   = '0;
        wvalid  = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wlast   = 1'b0;
        bready  = 1'b0;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        idleInputs();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_arready", 32'(arready), 32'd0);
        checkOutput("rst_awready", 32'(awready), 32'd0);
        checkOutput("rst_wready",  32'(wready),  32'd0);
        checkOutput("rst_rvalid",  32'(rvalid),  32'd0);
        checkOutput("rst_rlast",   32'(rlast),   32'd0);
        checkOutput("rst_bvalid",  32'(bvalid),  32'd0);
        checkOutput("rst_rdata",   rdata,        32'd0);
        checkOutput("rst_rresp",   32'(rresp),   32'd0);
        checkOutput("rst_bresp",   32'(bresp),   32'd0);
        rst = 1'b0;
    endtask

    // Called at a falling edge; returns at a falling edge after the B handshake.
    task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb,
                              input int lastBeat, output logic [1:0] resp);
        int waitCnt;
        awvalid = 1'b1;
        awaddr  = addr;
        awlen   = len;
        #1;
        waitCnt = 0;
        while (awready !== 1'b1 && waitCnt < 50) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        checkOutput("aw_handshake", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wdata  = wrData[i];
            wstrb  = strb;
            wlast  = (i == lastBeat);
            #1;
            waitCnt = 0;
            while (wready !== 1'b1 && waitCnt < 50) begin
                @(negedge clk);
                #1;
                waitCnt++;
            end
            checkOutput($sformatf("w_beat%0d_ready", i), 32'(wready), 32'd1);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        #1;
        waitCnt = 0;
        while (bvalid !== 1'b1 && waitCnt < 50) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        checkOutput("b_valid", 32'(bvalid), 32'd1);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Checks every visible beat against expData/expResp, including beats held during stalls.
    task automatic readBurst(input string tag, input logic [31:0] addr, input logic [7:0] len, input bit stall);
        int waitCnt;
        int idx;
        int cyc;
        logic [3:0] pat;
        pat     = 4'b1001;
        arvalid = 1'b1;
        araddr  = addr;
        arlen   = len;
        #1;
        checkOutput({tag, "_aw_blocked"}, 32'(awready), 32'd0);
        waitCnt = 0;
        while (arready !== 1'b1 && waitCnt < 50) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        checkOutput({tag, "_ar_handshake"}, 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        checkOutput({tag, "_issue_rvalid"}, 32'(rvalid), 32'd0);
        idx = 0;
        cyc = 0;
        while (idx <= int'(len) && cyc < 200) begin
            @(negedge clk);
            rready = stall ? pat[cyc % 4] : 1'b1;
            #1;
            if (cyc == 0) begin
                checkOutput({tag, "_first_rvalid"}, 32'(rvalid), 32'd1);
            end
            checkOutput({tag, "_awready_busy"}, 32'(awready), 32'd0);
            if (rvalid === 1'b1) begin
                checkOutput($sformatf("%s_beat%0d_data", tag, idx), rdata, expData[idx]);
                checkOutput($sformatf("%s_beat%0d_resp", tag, idx), 32'(rresp), 32'(expResp[idx]));
                checkOutput($sformatf("%s_beat%0d_last", tag, idx), 32'(rlast), 32'(idx == int'(len)));
                if (rready) idx++;
            end
            cyc++;
        end
        checkOutput({tag, "_beat_count"}, 32'(idx), 32'(len) + 32'd1);
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        applyReset();
        @(negedge clk);
        #1;
        checkOutput("arready_after_reset", 32'(arready), 32'd1);

        $display("[TB] 16-beat write and read-back at 0x40");
        for (int i = 0; i < 16; i++) begin
            wrData[i]  = 32'h0000_1000 + 32'(i);
            expData[i] = 32'h0000_1000 + 32'(i);
            expResp[i] = 2'b00;
        end
        writeBurst(32'h40, 8'd15, 4'hF, 15, respSeen);
        checkOutput("bresp_full_burst", 32'(respSeen), 32'd0);
        readBurst("rd40", 32'h40, 8'd15, 1'b0);

        $display("[TB] Same read with rready pattern 1,0,0,1");
        readBurst("rd40_stall", 32'h40, 8'd15, 1'b1);

        $display("[TB] AR and AW together: read first");
        awvalid = 1'b1;
        awaddr  = 32'h8;
        awlen   = 8'd0;
        readBurst("rd_arb", 32'h40, 8'd3, 1'b0);
        #1;
        checkOutput("awready_after_read", 32'(awready), 32'd1);
        wrData[0] = 32'h1122_3344;
        writeBurst(32'h8, 8'd0, 4'hF, 0, respSeen);
        checkOutput("bresp_arb_write", 32'(respSeen), 32'd0);

        $display("[TB] Byte strobes 0x5 at 0x8");
        wrData[0] = 32'hAABB_CCDD;
        writeBurst(32'h8, 8'd0, 4'h5, 0, respSeen);
        checkOutput("bresp_strobe", 32'(respSeen), 32'd0);
        expData[0] = 32'h11BB_33DD;
        expResp[0] = 2'b00;
        readBurst("rd_strobe", 32'h8, 8'd0, 1'b0);

        $display("[TB] wlast early on beat 1 of 4");
        for (int i = 0; i < 4; i++) wrData[i] = 32'hA0A0_0000 + 32'(i);
        writeBurst(32'h0, 8'd3, 4'hF, 1, respSeen);
        checkOutput("bresp_wlast_mismatch", 32'(respSeen), 32'd2);

        $display("[TB] Out-of-range beats near the top of the array");
        wrData[0] = 32'hCAFE_0000;
        wrData[1] = 32'hCAFE_0001;
        writeBurst(32'h3FF8, 8'd1, 4'hF, 1, respSeen);
        checkOutput("bresp_top_ok", 32'(respSeen), 32'd0);
        wrData[0] = 32'hBEEF_0001;
        wrData[1] = 32'hBEEF_0002;
        writeBurst(32'h3FFC, 8'd1, 4'hF, 1, respSeen);
        checkOutput("bresp_oor_write", 32'(respSeen), 32'd2);
        expData[0] = 32'hCAFE_0000; expResp[0] = 2'b00;
        expData[1] = 32'hBEEF_0001; expResp[1] = 2'b00;
        expData[2] = 32'h0;         expResp[2] = 2'b10;
        expData[3] = 32'h0;         expResp[3] = 2'b10;
        readBurst("rd_oor", 32'h3FF8, 8'd3, 1'b0);

        $display("[TB] Reset in the middle of a write burst");
        awvalid = 1'b1;
        awaddr  = 32'h100;
        awlen   = 8'd7;
        #1;
        checkOutput("aw2_ready", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b1;
        wstrb   = 4'hF;
        wdata   = 32'h5555_0000;
        @(negedge clk);
        wdata   = 32'h5555_0001;
        @(negedge clk);
        wvalid  = 1'b0;
        #1;
        checkOutput("mid_burst_wready", 32'(wready), 32'd1);
        applyReset();
        @(negedge clk);
        #1;
        checkOutput("arready_after_mid_reset", 32'(arready), 32'd1);
        checkOutput("no_bvalid_after_reset", 32'(bvalid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            expData[i] = 32'hA0A0_0000 + 32'(i);
            expResp[i] = 2'b00;
        end
        readBurst("rd_keep", 32'h0, 8'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
